instruction_fetch_unit: RTL and testbench

- IF stage of the 5-stage MIPS pipeline; the producer end of the IF/ID interface that the decode stage consumes.
- Owns the PC register and issues in-order requests to instruction memory over a valid/ready handshake.
- Buffers returned words in a small prefetch FIFO, then drives the IF/ID register (instruction, PC+4, valid).
- Accepts branch/jump redirects and the flush from decode; accepts a stall from hazard detection.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_buffer.sv | 67 ++++++
 rtl/instruction_fetch_unit.sv | 185 ++++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The fetch stage optionally exposes performance counters when the
// IF_PERF_COUNT_EN macro is defined (see instruction_fetch_unit).
package fetch_pkg;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One prefetched word together with the PC+4 that decode expects alongside it
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } fetch_entry_t;

    // Source selected for the IF/ID register on each clock
    typedef enum logic [1:0] {
        IFID_NOP  = 2'd0,
        IFID_HOLD = 2'd1,
        IFID_LOAD = 2'd2
    } ifid_sel_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding fetched words between the instruction
// memory response port and the IF/ID register. Clear wins over push so a
// redirect discards everything, including a word arriving that same cycle.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output fetch_entry_t  head_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    fetch_entry_t  slots [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !clear && !full;
    assign do_pop    = pop && !clear && !empty;
    assign head_data = slots[rd_ptr];

    // Pointer and occupancy bookkeeping; clear empties the buffer outright
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

    // Entry storage needs no reset; occupancy alone says what is valid
    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage of the 5-stage MIPS pipeline: owns the PC, issues in-order
// instruction memory requests, buffers responses and drives IF/ID.
// Defining IF_PERF_COUNT_EN adds fetch and redirect counters as outputs.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imemReqValid,
    input  logic        imemReqReady,
    output logic [31:0] imemReqAddr,
    input  logic        imemRespValid,
    input  logic [31:0] imemRespData,
    input  logic        stallInput,
    input  logic        branchControlInput,
    input  logic [31:0] pcBranchInput,
    input  logic        jumpInput,
    input  logic [31:0] pcJumpInput,
    input  logic        ifFlushInput,
    output logic [31:0] instructionOutput,
    output logic [31:0] pc4Output,
    output logic        validOutput
`ifdef IF_PERF_COUNT_EN
    ,
    output logic [31:0] fetchCountOutput,
    output logic [31:0] flushCountOutput
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_LIMIT = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]   pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_count;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   inflight_total;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;
    fetch_entry_t  fifo_in;
    fetch_entry_t  fifo_head;
    logic          redirect;
    logic [31:0]   target;
    logic          req_fire;
    logic          resp_keep;
    logic          resp_drop;
    ifid_sel_t     ifid_sel;

    assign redirect = jumpInput | branchControlInput;
    assign target   = jumpInput ? pcJumpInput : pcBranchInput;

    // Requests are capped so every in-flight word is guaranteed a buffer slot
    assign inflight_total = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imemReqValid   = reset && !redirect && (inflight_total < DEPTH_LIMIT);
    assign imemReqAddr    = pc;
    assign req_fire       = imemReqValid && imemReqReady;

    // Responses belonging to a squashed stream are counted off and discarded
    assign resp_drop = imemRespValid && (drop_count != '0);
    assign resp_keep = imemRespValid && (drop_count == '0);
    assign fifo_push = resp_keep && !fifo_full;
    assign fifo_in   = '{instr: imemRespData, pc4: resp_pc + 32'd4};

    fetch_buffer #(
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_buffer (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // An accepted response must always find room in the prefetch buffer
    assert property (@(posedge clk) disable iff (!reset)
                     !(resp_keep && !redirect && fifo_full));

    // Fetch PC: jumps to the redirect target, otherwise advances per accepted request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= target;
        end else if (req_fire) begin
            pc <= pc + 32'd4;
        end
    end

    // Address of the next kept response, used to rebuild PC+4 for each word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_pc <= RESET_PC;
        end else if (redirect) begin
            resp_pc <= target;
        end else if (resp_keep) begin
            resp_pc <= resp_pc + 32'd4;
        end
    end

    // Outstanding requests and how many of them are stale after a redirect
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outstanding <= '0;
            drop_count  <= '0;
        end else begin
            if (req_fire && !imemRespValid) begin
                outstanding <= outstanding + 1'b1;
            end else if (!req_fire && imemRespValid) begin
                outstanding <= outstanding - 1'b1;
            end
            if (redirect) begin
                drop_count <= outstanding - CW'(imemRespValid);
            end else if (resp_drop) begin
                drop_count <= drop_count - 1'b1;
            end
        end
    end

    // Choose what IF/ID takes next: squash, hold for a hazard, or pop a word
    always_comb begin
        ifid_sel = IFID_NOP;
        if (ifFlushInput || redirect) begin
            ifid_sel = IFID_NOP;
        end else if (stallInput) begin
            ifid_sel = IFID_HOLD;
        end else if (!fifo_empty) begin
            ifid_sel = IFID_LOAD;
        end
    end

    assign fifo_pop = (ifid_sel == IFID_LOAD);

    // IF/ID pipeline register seen by decode
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instructionOutput <= NOP;
            pc4Output         <= 32'h0;
            validOutput       <= 1'b0;
        end else begin
            case (ifid_sel)
                IFID_LOAD: begin
                    instructionOutput <= fifo_head.instr;
                    pc4Output         <= fifo_head.pc4;
                    validOutput       <= 1'b1;
                end
                IFID_HOLD: begin
                end
                default: begin
                    instructionOutput <= NOP;
                    pc4Output         <= 32'h0;
                    validOutput       <= 1'b0;
                end
            endcase
        end
    end

`ifdef IF_PERF_COUNT_EN
    // Count instructions handed to decode and redirects taken
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetchCountOutput <= 32'h0;
            flushCountOutput <= 32'h0;
        end else begin
            if (fifo_pop) begin
                fetchCountOutput <= fetchCountOutput + 32'd1;
            end
            if (redirect) begin
                flushCountOutput <= flushCountOutput + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: directed vector table, hand-written
// redirect/stall/backpressure/reset sequences and a randomized run, all
// checked against a stream-level reference model of the fetch stage.
module tb_instruction_fetch_unit;
    import fetch_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        imemReqValid;
    logic        imemReqReady;
    logic [31:0] imemReqAddr;
    logic        imemRespValid;
    logic [31:0] imemRespData;
    logic        stallInput;
    logic        branchControlInput;
    logic [31:0] pcBranchInput;
    logic        jumpInput;
    logic [31:0] pcJumpInput;
    logic        ifFlushInput;
    logic [31:0] instructionOutput;
    logic [31:0] pc4Output;
    logic        validOutput;
`ifdef IF_PERF_COUNT_EN
    logic [31:0] fetchCountOutput;
    logic [31:0] flushCountOutput;
`endif

    instruction_fetch_unit #(
        .RESET_PC   (RPC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .imemReqValid       (imemReqValid),
        .imemReqReady       (imemReqReady),
        .imemReqAddr        (imemReqAddr),
        .imemRespValid      (imemRespValid),
        .imemRespData       (imemRespData),
        .stallInput         (stallInput),
        .branchControlInput (branchControlInput),
        .pcBranchInput      (pcBranchInput),
        .jumpInput          (jumpInput),
        .pcJumpInput        (pcJumpInput),
        .ifFlushInput       (ifFlushInput),
        .instructionOutput  (instructionOutput),
        .pc4Output          (pc4Output),
        .validOutput        (validOutput)
`ifdef IF_PERF_COUNT_EN
        ,
        .fetchCountOutput   (fetchCountOutput),
        .flushCountOutput   (flushCountOutput)
`endif
    );

    typedef struct {
        logic        stall;
        logic        flush;
        logic        jump;
        logic        branch;
        logic        ready;
        logic [31:0] pcj;
        logic [31:0] pcb;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_v;
        logic [31:0] exp_iaddr;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mreq_t;

    int          checks;
    int          errors;
    int          cyc;
    int          epoch;
    int          fixed_lat;
    bit          rand_lat;
    int          deliveries;
    mreq_t       mem_q[$];
    logic [31:0] buf_q[$];
    logic [31:0] model_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc4;
    logic        exp_valid;
    logic [31:0] model_fetch_cnt;
    logic [31:0] model_flush_cnt;
    vec_t        vecs[13];

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run can never hang
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h3C00_0000 ^ {a[15:0], 16'h0000};
    endfunction

    function automatic stim_t idle(input logic ready);
        stim_t s;
        s = '{stall: 1'b0, flush: 1'b0, jump: 1'b0, branch: 1'b0,
              ready: ready, pcj: 32'h0, pcb: 32'h0};
        return s;
    endfunction

    function automatic vec_t mk(input logic st, input logic fl, input logic jp,
                                input logic br, input logic [31:0] pcj,
                                input logic [31:0] pcb, input logic rv,
                                input logic [31:0] addr, input logic v,
                                input logic [31:0] iaddr);
        vec_t r;
        r.s = '{stall: st, flush: fl, jump: jp, branch: br, ready: 1'b1,
                pcj: pcj, pcb: pcb};
        r.exp_rv    = rv;
        r.exp_addr  = addr;
        r.exp_v     = v;
        r.exp_iaddr = iaddr;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic clearModel();
        mem_q.delete();
        buf_q.delete();
        model_pc        = RPC;
        epoch           = 0;
        exp_instr       = NOP;
        exp_pc4         = 32'h0;
        exp_valid       = 1'b0;
        model_fetch_cnt = 32'h0;
        model_flush_cnt = 32'h0;
    endtask

    task automatic resetDut();
        reset              = 1'b0;
        stallInput         = 1'b0;
        ifFlushInput       = 1'b0;
        jumpInput          = 1'b0;
        branchControlInput = 1'b0;
        pcJumpInput        = 32'h0;
        pcBranchInput      = 32'h0;
        imemReqReady       = 1'b0;
        imemRespValid      = 1'b0;
        imemRespData       = 32'h0;
        clearModel();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    // One clock of stimulus; the memory and the stream model advance together
    task automatic applyStimulus(input stim_t s, output logic obs_rv,
                                 output logic [31:0] obs_addr);
        logic        redirect;
        logic        accept;
        logic        resp;
        logic        exp_rv;
        logic [31:0] acc_addr;
        logic [31:0] target;
        logic [31:0] a;
        mreq_t       hd;
        int          lat;

        @(negedge clk);
        stallInput         = s.stall;
        ifFlushInput       = s.flush;
        jumpInput          = s.jump;
        branchControlInput = s.branch;
        pcJumpInput        = s.pcj;
        pcBranchInput      = s.pcb;
        imemReqReady       = s.ready;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imemRespValid = 1'b1;
            imemRespData  = word(mem_q[0].addr);
        end else begin
            imemRespValid = 1'b0;
            imemRespData  = $urandom;
        end
        #1;
        redirect = s.jump | s.branch;
        target   = s.jump ? s.pcj : s.pcb;
        exp_rv   = !redirect && ((mem_q.size() + buf_q.size()) < DEPTH);
        obs_rv   = imemReqValid;
        obs_addr = imemReqAddr;
        checkOutput("req_valid", {31'b0, imemReqValid}, {31'b0, exp_rv});
        if (exp_rv && imemReqValid) begin
            checkOutput("req_addr", imemReqAddr, model_pc);
        end
        accept   = imemReqValid && s.ready;
        acc_addr = imemReqAddr;
        resp     = imemRespValid;

        @(posedge clk);
        hd = '{addr: 32'h0, epoch: -1, due: 0};
        if (resp) begin
            hd = mem_q.pop_front();
        end
        if (s.flush || redirect) begin
            exp_instr = NOP;
            exp_pc4   = 32'h0;
            exp_valid = 1'b0;
        end else if (!s.stall) begin
            if (buf_q.size() > 0) begin
                a         = buf_q.pop_front();
                exp_instr = word(a);
                exp_pc4   = a + 32'd4;
                exp_valid = 1'b1;
                deliveries++;
                model_fetch_cnt = model_fetch_cnt + 32'd1;
            end else begin
                exp_instr = NOP;
                exp_pc4   = 32'h0;
                exp_valid = 1'b0;
            end
        end
        lat = rand_lat ? int'($urandom_range(1, 4)) : fixed_lat;
        if (accept) begin
            mem_q.push_back('{addr: acc_addr, epoch: epoch, due: cyc + lat});
            if (!redirect) begin
                model_pc = model_pc + 32'd4;
            end
        end
        if (redirect) begin
            buf_q.delete();
            epoch++;
            model_pc        = target;
            model_flush_cnt = model_flush_cnt + 32'd1;
        end else if (resp && hd.epoch == epoch) begin
            buf_q.push_back(hd.addr);
        end
        cyc++;

        #1;
        checkOutput("ifid_valid", {31'b0, validOutput}, {31'b0, exp_valid});
        checkOutput("ifid_instr", instructionOutput, exp_instr);
        checkOutput("ifid_pc4", pc4Output, exp_pc4);
`ifdef IF_PERF_COUNT_EN
        checkOutput("fetch_count", fetchCountOutput, model_fetch_cnt);
        checkOutput("flush_count", flushCountOutput, model_flush_cnt);
`endif
    endtask

    // Stimulus sequence
    initial begin
        logic        rv;
        logic [31:0] ad;
        logic [31:0] held_addr;
        bit          found;
        stim_t       s;
        int          r;

        checks     = 0;
        errors     = 0;
        cyc        = 0;
        deliveries = 0;
        fixed_lat  = 1;
        rand_lat   = 1'b0;
        clearModel();

        vecs[0]  = mk(0, 0, 0, 0, 32'h0,   32'h0,   1, 32'h00,  0, 32'h0);
        vecs[1]  = mk(0, 0, 0, 0, 32'h0,   32'h0,   1, 32'h04,  0, 32'h0);
        vecs[2]  = mk(0, 0, 0, 0, 32'h0,   32'h0,   0, 32'h0,   1, 32'h00);
        vecs[3]  = mk(0, 0, 0, 0, 32'h0,   32'h0,   1, 32'h08,  1, 32'h04);
        vecs[4]  = mk(0, 0, 0, 0, 32'h0,   32'h0,   1, 32'h0C,  0, 32'h0);
        vecs[5]  = mk(0, 0, 0, 0, 32'h0,   32'h0,   0, 32'h0,   1, 32'h08);
        vecs[6]  = mk(0, 0, 0, 0, 32'h0,   32'h0,   1, 32'h10,  1, 32'h0C);
        vecs[7]  = mk(0, 0, 1, 0, 32'h40,  32'h0,   0, 32'h0,   0, 32'h0);
        vecs[8]  = mk(0, 0, 0, 0, 32'h0,   32'h0,   1, 32'h40,  0, 32'h0);
        vecs[9]  = mk(0, 0, 0, 0, 32'h0,   32'h0,   1, 32'h44,  0, 32'h0);
        vecs[10] = mk(0, 0, 0, 0, 32'h0,   32'h0,   0, 32'h0,   1, 32'h40);
        vecs[11] = mk(0, 0, 1, 1, 32'h100, 32'h200, 0, 32'h0,   0, 32'h0);
        vecs[12] = mk(0, 0, 0, 0, 32'h0,   32'h0,   1, 32'h100, 0, 32'h0);

        // Reset values
        resetDut();
        #1;
        checkOutput("reset_valid", {31'b0, validOutput}, 32'h0);
        checkOutput("reset_instr", instructionOutput, NOP);
        checkOutput("reset_pc4", pc4Output, 32'h0);

        // Directed vector table with a 1-cycle memory
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].s, rv, ad);
            checkOutput($sformatf("vec%0d_rv", i), {31'b0, rv}, {31'b0, vecs[i].exp_rv});
            if (vecs[i].exp_rv) begin
                checkOutput($sformatf("vec%0d_addr", i), ad, vecs[i].exp_addr);
            end
            checkOutput($sformatf("vec%0d_valid", i), {31'b0, validOutput}, {31'b0, vecs[i].exp_v});
            if (vecs[i].exp_v) begin
                checkOutput($sformatf("vec%0d_instr", i), instructionOutput, word(vecs[i].exp_iaddr));
                checkOutput($sformatf("vec%0d_pc4", i), pc4Output, vecs[i].exp_iaddr + 32'd4);
            end else begin
                checkOutput($sformatf("vec%0d_nop", i), instructionOutput, NOP);
            end
        end

        // Jump with two requests in flight on a 3-cycle memory
        fixed_lat = 3;
        resetDut();
        applyStimulus(idle(1'b1), rv, ad);
        applyStimulus(idle(1'b1), rv, ad);
        s     = idle(1'b1);
        s.jump = 1'b1;
        s.pcj  = 32'h0000_0040;
        applyStimulus(s, rv, ad);
        checkOutput("jump_bubble", {31'b0, validOutput}, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            applyStimulus(idle(1'b1), rv, ad);
            found = validOutput;
        end
        checkOutput("jump_first_found", {31'b0, found}, 32'h1);
        checkOutput("jump_first_instr", instructionOutput, word(32'h40));
        checkOutput("jump_first_pc4", pc4Output, 32'h44);

        // Three stall cycles: IF/ID frozen while the buffer fills
        fixed_lat = 1;
        resetDut();
        repeat (4) applyStimulus(idle(1'b1), rv, ad);
        s       = idle(1'b1);
        s.stall = 1'b1;
        applyStimulus(s, rv, ad);
        applyStimulus(s, rv, ad);
        applyStimulus(s, rv, ad);
        checkOutput("stall_req_gated", {31'b0, rv}, 32'h0);
        checkOutput("stall_hold_instr", instructionOutput, word(32'h4));
        checkOutput("stall_hold_pc4", pc4Output, 32'h8);
        applyStimulus(idle(1'b1), rv, ad);
        checkOutput("stall_resume1_pc4", pc4Output, 32'hC);
        applyStimulus(idle(1'b1), rv, ad);
        checkOutput("stall_resume2_pc4", pc4Output, 32'h10);
        checkOutput("stall_resume2_instr", instructionOutput, word(32'hC));

        // Memory not ready for four cycles: address held, PC frozen
        resetDut();
        held_addr = RPC;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(idle(1'b0), rv, ad);
            checkOutput($sformatf("notready%0d_rv", i), {31'b0, rv}, 32'h1);
            checkOutput($sformatf("notready%0d_addr", i), ad, held_addr);
        end
        applyStimulus(idle(1'b1), rv, ad);
        checkOutput("ready_accept_addr", ad, held_addr);
        applyStimulus(idle(1'b1), rv, ad);
        checkOutput("ready_next_addr", ad, held_addr + 32'd4);

        // Randomized traffic including wrap-around targets
        rand_lat   = 1'b1;
        resetDut();
        deliveries = 0;
        for (int i = 0; i < 1500; i++) begin
            s.stall  = ($urandom_range(0, 4) == 0);
            s.flush  = ($urandom_range(0, 19) == 0);
            s.jump   = ($urandom_range(0, 19) == 0);
            s.branch = ($urandom_range(0, 19) == 0);
            s.ready  = ($urandom_range(0, 9) < 7);
            r = int'($urandom_range(0, 9));
            s.pcj = (r == 0) ? 32'hFFFF_FFF8 : (32'($urandom_range(0, 1023)) << 2);
            s.pcb = (r == 1) ? 32'hFFFF_FFFC : (32'($urandom_range(0, 1023)) << 2);
            applyStimulus(s, rv, ad);
        end
        checkOutput("random_liveness", {31'b0, (deliveries >= 50)}, 32'h1);

        // Asynchronous reset in the middle of a stream
        #1;
        reset = 1'b0;
        #1;
        checkOutput("midreset_valid", {31'b0, validOutput}, 32'h0);
        checkOutput("midreset_instr", instructionOutput, NOP);
        checkOutput("midreset_pc4", pc4Output, 32'h0);
        checkOutput("midreset_req_valid", {31'b0, imemReqValid}, 32'h0);
        checkOutput("midreset_pc", imemReqAddr, RPC);
`ifdef IF_PERF_COUNT_EN
        checkOutput("midreset_fetch_count", fetchCountOutput, 32'h0);
        checkOutput("midreset_flush_count", flushCountOutput, 32'h0);
`endif
        rand_lat  = 1'b0;
        fixed_lat = 1;
        resetDut();
        applyStimulus(idle(1'b1), rv, ad);
        checkOutput("postreset_addr", ad, RPC);
        applyStimulus(idle(1'b1), rv, ad);
        applyStimulus(idle(1'b1), rv, ad);
        checkOutput("postreset_first_pc4", pc4Output, RPC + 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
